reg_ctx_engine: RTL and testbench
=================================

# reg_ctx_engine

Context save/restore engine for the 32×32 integer register file. On command, it walks architectural registers x1..x31. In save mode it reads each register through a register-file read port and writes it to a memory save area. In restore mode it reads each word from memory and writes it back through the register-file write port. It sits between the OS context-switch control logic, the register file and the data-memory/cache port, and owns both register-file ports while BUSY is high.

## Interface
Parameters:
- DATA_W, 32, register and memory data width
- RADDR_W, 5, register address width
- MADDR_W, 32, memory byte-address width
- FIRST_REG, 1, first register transferred; x0 is never saved or restored
- LAST_REG, 31, last register transferred

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  command strobe, sampled only in IDLE
- MODE  in  1  0 = save (regfile→memory), 1 = restore (memory→regfile); sampled with START
- BASE_ADDR  in  MADDR_W  save-area base byte address; sampled with START
- BUSY  out  1  high from the cycle after START is accepted until DONE
- DONE  out  1  one-cycle completion pulse
- RF_RADDR  out  RADDR_W  register-file read address
- RF_RDATA  in  DATA_W  register-file read data, valid one cycle after RF_RADDR changes
- RF_WADDR  out  RADDR_W  register-file write address
- RF_WDATA  out  DATA_W  register-file write data
- RF_WRITE  out  1  register-file write enable, one-cycle pulse per register
- MEM_REQ  out  1  memory request, held until acknowledged
- MEM_WE  out  1  1 = write, 0 = read; valid while MEM_REQ
- MEM_ADDR  out  MADDR_W  word-aligned byte address
- MEM_WDATA  out  DATA_W  write data
- MEM_RDATA  in  DATA_W  read data, valid in the MEM_ACK cycle
- MEM_ACK  in  1  single-cycle acknowledge; ignored when MEM_REQ is low

## Operation
- States are IDLE, RD_SETUP, MEM_XFER, RF_WR and FIN.
- IDLE: START=1 latches MODE, BASE_ADDR and idx=FIRST_REG.
  - Save goes to RD_SETUP.
  - Restore goes to MEM_XFER.
- RD_SETUP (save only): drive RF_RADDR=idx for one cycle, then capture RF_RDATA into the data register and go to MEM_XFER.
- MEM_XFER:
  - Drives MEM_REQ=1, MEM_ADDR=BASE_ADDR+(idx<<2) (modulo 2^MADDR_W), MEM_WE=~MODE, MEM_WDATA=data register.
  - All request fields stay stable until MEM_ACK.
  - On MEM_ACK in save mode: if idx==LAST_REG go to FIN, else idx+1 and go to RD_SETUP.
  - On MEM_ACK in restore mode: capture MEM_RDATA and go to RF_WR.
- RF_WR: RF_WRITE=1, RF_WADDR=idx, RF_WDATA=captured data. Then go to FIN if idx==LAST_REG, else idx+1 and go to MEM_XFER.
- FIN: DONE=1 and BUSY=0 in this cycle, then go to IDLE.
- START while not IDLE is ignored, with no queuing. START in the FIN cycle is ignored.
- MEM_ACK outside MEM_XFER is ignored.
- The address sum wraps silently. BASE_ADDR[1:0] is used as given; alignment is the caller's responsibility.
- Slot 0 (BASE_ADDR+0) is never accessed.

## Timing
- Reset values: state IDLE, idx=FIRST_REG, data register 0. BUSY, DONE, RF_WRITE and MEM_REQ are 0. All address and data outputs are 0.
- Reset mid-operation aborts immediately. No partial RF_WRITE or MEM_REQ is asserted after RESET_N falls. Registers already transferred stay transferred.
- START is accepted at edge 0; BUSY is high from cycle 1.
- Save with zero-wait ack (MEM_ACK in the first MEM_XFER cycle): 2 cycles per register. DONE is high in cycle 63.
- Restore with zero-wait ack: 2 cycles per register. DONE is high in cycle 63.
- Each memory wait cycle adds exactly one cycle.
- RF_WRITE and MEM_REQ are never high in the same cycle.
- At most one RF_WRITE per register.

## Structure
- Package reg_ctx_pkg holds:
  - the state enum: IDLE, RD_SETUP, MEM_XFER, RF_WR, FIN
  - MODE_SAVE=0 and MODE_RESTORE=1
  - the default widths
- Single module; no sub-module. The address adder and idx counter are inline.

## Test plan
- Save, zero-wait: preload xN=32'hA000_0000+N, BASE=32'h0000_1000, memory acks in the same cycle → 31 writes, addr 0x1004..0x107C, data matches; DONE at cycle 63; no RF_WRITE.
- Restore, zero-wait: memory word at 0x2000+4N = 32'h5A00_0000+N → regfile xN matches for N=1..31, x0 untouched; DONE at cycle 63.
- Memory stalls: ack after 3 wait cycles on every request → request fields held stable across the stalls; DONE at cycle 63+31×3=156.
- START asserted while BUSY with MODE flipped → ignored; transfer completes in the original mode; exactly one DONE.
- RESET_N pulled low during restore at register 10 → all outputs 0 asynchronously; x1..x9 restored, x10..x31 unchanged; a fresh START works.
- BASE_ADDR=32'hFFFF_FFC0, save → addresses wrap past 0xFFFF_FFFC to 0x0000_0000..0x0000_003C.

Source files
------------

// File: rtl/reg_ctx_pkg.sv
// Shared types and default widths for the register context save/restore engine.
package reg_ctx_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int RADDR_W_DEF   = 5;
    localparam int MADDR_W_DEF   = 32;
    localparam int FIRST_REG_DEF = 1;
    localparam int LAST_REG_DEF  = 31;

    localparam logic MODE_SAVE    = 1'b0;
    localparam logic MODE_RESTORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        MEM_XFER,
        RF_WR,
        FIN
    } state_t;

endpackage

// File: rtl/reg_ctx_engine.sv
// Walks x1..x31 moving each register between the register file and a memory
// save area. Owns both register-file ports while BUSY is high.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for START; latches MODE, BASE_ADDR, idx=FIRST_REG
// RD_SETUP | save: present idx on RF_RADDR, capture RF_RDATA at the edge
// MEM_XFER | memory request for slot idx, held until MEM_ACK
// RF_WR    | restore: one-cycle write of the captured word into x[idx]
// FIN      | one-cycle DONE pulse, BUSY low, START ignored
module reg_ctx_engine
    import reg_ctx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RADDR_W   = RADDR_W_DEF,
    parameter int MADDR_W   = MADDR_W_DEF,
    parameter int FIRST_REG = FIRST_REG_DEF,
    parameter int LAST_REG  = LAST_REG_DEF
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               MODE,
    input  logic [MADDR_W-1:0] BASE_ADDR,
    output logic               BUSY,
    output logic               DONE,
    output logic [RADDR_W-1:0] RF_RADDR,
    input  logic [DATA_W-1:0]  RF_RDATA,
    output logic [RADDR_W-1:0] RF_WADDR,
    output logic [DATA_W-1:0]  RF_WDATA,
    output logic               RF_WRITE,
    output logic               MEM_REQ,
    output logic               MEM_WE,
    output logic [MADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0]  MEM_WDATA,
    input  logic [DATA_W-1:0]  MEM_RDATA,
    input  logic               MEM_ACK
);

    localparam logic [RADDR_W-1:0] FIRST_IDX = RADDR_W'(FIRST_REG);
    localparam logic [RADDR_W-1:0] LAST_IDX  = RADDR_W'(LAST_REG);

    state_t             state, state_nx;
    logic [RADDR_W-1:0] idx, idx_nx;
    logic [DATA_W-1:0]  data, data_nx;
    logic               mode, mode_nx;
    logic [MADDR_W-1:0] base, base_nx;
    logic [MADDR_W-1:0] slot_addr;

    // Slot address wraps modulo 2^MADDR_W; BASE_ADDR alignment is not enforced.
    assign slot_addr = base + (MADDR_W'(idx) << 2);

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            idx   <= FIRST_IDX;
            data  <= '0;
            mode  <= MODE_SAVE;
            base  <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            data  <= data_nx;
            mode  <= mode_nx;
            base  <= base_nx;
        end
    end

    // Next-state and outputs; outputs are decoded from state so they drop to 0
    // as soon as reset forces IDLE.
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        data_nx   = data;
        mode_nx   = mode;
        base_nx   = base;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        RF_RADDR  = '0;
        RF_WADDR  = '0;
        RF_WDATA  = '0;
        RF_WRITE  = 1'b0;
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;

        case (state)
            IDLE: begin
                if (START) begin
                    mode_nx  = MODE;
                    base_nx  = BASE_ADDR;
                    idx_nx   = FIRST_IDX;
                    state_nx = (MODE == MODE_RESTORE) ? MEM_XFER : RD_SETUP;
                end
            end
            RD_SETUP: begin
                BUSY     = 1'b1;
                RF_RADDR = idx;
                data_nx  = RF_RDATA;
                state_nx = MEM_XFER;
            end
            MEM_XFER: begin
                BUSY      = 1'b1;
                MEM_REQ   = 1'b1;
                MEM_WE    = (mode == MODE_SAVE);
                MEM_ADDR  = slot_addr;
                MEM_WDATA = data;
                if (MEM_ACK) begin
                    if (mode == MODE_SAVE) begin
                        if (idx == LAST_IDX) begin
                            state_nx = FIN;
                        end else begin
                            idx_nx   = idx + RADDR_W'(1);
                            state_nx = RD_SETUP;
                        end
                    end else begin
                        data_nx  = MEM_RDATA;
                        state_nx = RF_WR;
                    end
                end
            end
            RF_WR: begin
                BUSY     = 1'b1;
                RF_WRITE = 1'b1;
                RF_WADDR = idx;
                RF_WDATA = data;
                if (idx == LAST_IDX) begin
                    state_nx = FIN;
                end else begin
                    idx_nx   = idx + RADDR_W'(1);
                    state_nx = MEM_XFER;
                end
            end
            FIN: begin
                DONE     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Bench for reg_ctx_engine: register-file and memory models, table of directed
// transfers, randomized transfers, and hand sequences for abort and ignored START.
module tb_reg_ctx_engine;
    import reg_ctx_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic        MODE = 1'b0;
    logic [31:0] BASE_ADDR = '0;
    logic        BUSY, DONE, RF_WRITE, MEM_REQ, MEM_WE;
    logic [4:0]  RF_RADDR, RF_WADDR;
    logic [31:0] RF_RDATA, RF_WDATA, MEM_ADDR, MEM_WDATA;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;

    reg_ctx_engine dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .MODE(MODE), .BASE_ADDR(BASE_ADDR),
        .BUSY(BUSY), .DONE(DONE), .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA),
        .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA), .RF_WRITE(RF_WRITE),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rf[32];
    logic [31:0] snap[32];
    logic [31:0] mem[logic [31:0]];
    assign RF_RDATA = rf[RF_RADDR];

    int tests = 0;
    int fails = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int done_cyc, n_done, n_rfw, viol, total_waits;
    bit aborted;

    typedef struct {
        bit          mode;
        logic [31:0] base;
        int          waits;
        int          exp_done;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic fill_rf(input logic [31:0] pat);
        rf[0] = 32'h0BAD_0000;
        for (int n = 1; n < 32; n++) rf[n] = pat + 32'(n);
    endtask

    task automatic fill_mem(input logic [31:0] base, input logic [31:0] pat);
        for (int n = 0; n < 32; n++) mem[base + 32'(4 * n)] = pat + 32'(n);
    endtask

    task automatic snap_rf();
        for (int n = 0; n < 32; n++) snap[n] = rf[n];
    endtask

    // Drives one command and services the memory with the chosen wait profile.
    task automatic run_op(input bit mode, input logic [31:0] base, input int waits,
                          input bit rand_waits, input int flip_at, input int tail,
                          input bit do_abort, input logic [31:0] abort_addr);
        int          cyc, stall, cur_wait;
        bit          pending;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        obs_addr.delete();
        obs_data.delete();
        done_cyc = -1; n_done = 0; n_rfw = 0; viol = 0; total_waits = 0; aborted = 0;
        pending = 0; stall = 0; h_addr = '0; h_wdata = '0; h_we = 1'b0;
        cur_wait = rand_waits ? int'($urandom_range(0, 3)) : waits;
        @(negedge CLK);
        START = 1'b1; MODE = mode; BASE_ADDR = base;
        @(posedge CLK);
        cyc = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge CLK);
            cyc++;
            START = 1'b0;
            MEM_ACK = 1'b0;
            MEM_RDATA = $urandom();
            if (cyc == flip_at) begin
                START = 1'b1; MODE = ~mode; BASE_ADDR = ~base;
            end
            if (RF_WRITE && MEM_REQ) viol++;
            if (done_cyc < 0 && !DONE && !BUSY) viol++;
            if (DONE && BUSY) viol++;
            if (done_cyc >= 0 && (BUSY || DONE || MEM_REQ || RF_WRITE)) viol++;
            if (MEM_REQ) begin
                if (pending && (MEM_ADDR !== h_addr || MEM_WE !== h_we || MEM_WDATA !== h_wdata))
                    viol++;
                if (MEM_WE !== (mode == MODE_SAVE)) viol++;
                if (do_abort && MEM_ADDR == abort_addr) begin
                    #1 RESET_N = 1'b0;
                    aborted = 1;
                    break;
                end
                pending = 1; h_addr = MEM_ADDR; h_we = MEM_WE; h_wdata = MEM_WDATA;
                if (stall < cur_wait) begin
                    stall++;
                    total_waits++;
                end else begin
                    MEM_ACK = 1'b1;
                    pending = 0;
                    stall = 0;
                    cur_wait = rand_waits ? int'($urandom_range(0, 3)) : waits;
                    obs_addr.push_back(MEM_ADDR);
                    if (MEM_WE) begin
                        obs_data.push_back(MEM_WDATA);
                        mem[MEM_ADDR] = MEM_WDATA;
                    end else begin
                        MEM_RDATA = mem_rd(MEM_ADDR);
                    end
                end
            end
            if (RF_WRITE) begin
                n_rfw++;
                rf[RF_WADDR] = RF_WDATA;
            end
            if (DONE) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                START = 1'b1; MODE = ~mode;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + tail) break;
        end
        START = 1'b0;
        MEM_ACK = 1'b0;
    endtask

    // Reference outcome: slot N of the save area holds xN, slot 0 never touched.
    task automatic verify_op(input string tag, input bit mode, input logic [31:0] base,
                             input int exp_done);
        chk({tag, " done_cycle"}, done_cyc, exp_done);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " protocol_viol"}, viol, 0);
        chk({tag, " xfer_count"}, obs_addr.size(), 31);
        chk({tag, " rf_writes"}, n_rfw, mode ? 31 : 0);
        for (int n = 1; n < 32; n++) begin
            if (n - 1 < obs_addr.size())
                chk({tag, " addr"}, obs_addr[n - 1], base + 32'(4 * n));
            if (mode == MODE_SAVE) begin
                if (n - 1 < obs_data.size())
                    chk({tag, " wdata"}, obs_data[n - 1], snap[n]);
            end else begin
                chk({tag, " rf_restored"}, rf[n], mem_rd(base + 32'(4 * n)));
            end
        end
        if (mode == MODE_RESTORE) chk({tag, " x0_untouched"}, rf[0], snap[0]);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " BUSY"}, 32'(BUSY), 0);
        chk({tag, " DONE"}, 32'(DONE), 0);
        chk({tag, " RF_WRITE"}, 32'(RF_WRITE), 0);
        chk({tag, " MEM_REQ"}, 32'(MEM_REQ), 0);
        chk({tag, " MEM_WE"}, 32'(MEM_WE), 0);
        chk({tag, " RF_RADDR"}, 32'(RF_RADDR), 0);
        chk({tag, " RF_WADDR"}, 32'(RF_WADDR), 0);
        chk({tag, " RF_WDATA"}, RF_WDATA, 0);
        chk({tag, " MEM_ADDR"}, MEM_ADDR, 0);
        chk({tag, " MEM_WDATA"}, MEM_WDATA, 0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1000, 0, 63, 32'h0000_1004, 32'h0000_107C};
        vecs[1] = '{1'b1, 32'h0000_2000, 0, 63, 32'h0000_2004, 32'h0000_207C};
        vecs[2] = '{1'b0, 32'h0000_1000, 3, 156, 32'h0000_1004, 32'h0000_107C};
        vecs[3] = '{1'b1, 32'h0000_2000, 3, 156, 32'h0000_2004, 32'h0000_207C};
        vecs[4] = '{1'b0, 32'hFFFF_FFC0, 0, 63, 32'hFFFF_FFC4, 32'h0000_003C};
        vecs[5] = '{1'b1, 32'h0000_6000, 1, 94, 32'h0000_6004, 32'h0000_607C};

        fill_rf(32'hA000_0000);
        #2;
        chk_outputs_zero("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);
        chk_outputs_zero("idle");

        foreach (vecs[i]) begin
            if (vecs[i].mode == MODE_SAVE) begin
                fill_rf(32'hA000_0000);
            end else begin
                fill_rf(32'h1111_0000);
                fill_mem(vecs[i].base, 32'h5A00_0000);
            end
            snap_rf();
            run_op(vecs[i].mode, vecs[i].base, vecs[i].waits, 1'b0, -1, 3, 1'b0, '0);
            verify_op($sformatf("vec%0d", i), vecs[i].mode, vecs[i].base, vecs[i].exp_done);
            if (obs_addr.size() == 31) begin
                chk($sformatf("vec%0d first_addr", i), obs_addr[0], vecs[i].first_addr);
                chk($sformatf("vec%0d last_addr", i), obs_addr[30], vecs[i].last_addr);
            end
        end

        for (int r = 0; r < 6; r++) begin
            bit          m;
            logic [31:0] b;
            m = 1'($urandom_range(0, 1));
            b = $urandom();
            for (int n = 0; n < 32; n++) begin
                rf[n] = $urandom();
                mem[b + 32'(4 * n)] = $urandom();
            end
            snap_rf();
            run_op(m, b, 0, 1'b1, -1, 3, 1'b0, '0);
            verify_op($sformatf("rand%0d", r), m, b, 63 + total_waits);
        end

        // START with flipped MODE while busy, plus START during FIN.
        fill_rf(32'hC000_0000);
        snap_rf();
        run_op(MODE_SAVE, 32'h0000_5000, 1, 1'b0, 10, 70, 1'b0, '0);
        verify_op("busy_start", MODE_SAVE, 32'h0000_5000, 94);

        // Reset while restoring x10.
        fill_rf(32'hDEAD_0000);
        fill_mem(32'h0000_3000, 32'h7700_0000);
        run_op(MODE_RESTORE, 32'h0000_3000, 0, 1'b0, -1, 3, 1'b1, 32'h0000_3028);
        chk("abort reached", 32'(aborted), 1);
        #1;
        chk_outputs_zero("abort");
        repeat (2) @(negedge CLK);
        chk("abort held RF_WRITE", 32'(RF_WRITE), 0);
        chk("abort held MEM_REQ", 32'(MEM_REQ), 0);
        for (int n = 1; n < 32; n++) begin
            if (n < 10) chk("abort kept", rf[n], 32'h7700_0000 + 32'(n));
            else        chk("abort untouched", rf[n], 32'hDEAD_0000 + 32'(n));
        end
        RESET_N = 1'b1;
        @(negedge CLK);
        fill_rf(32'hB000_0000);
        snap_rf();
        run_op(MODE_SAVE, 32'h0000_4000, 0, 1'b0, -1, 3, 1'b0, '0);
        verify_op("after_abort", MODE_SAVE, 32'h0000_4000, 63);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
